// File: rtl/dac_sched_pkg.sv
// AD5628 command codes, scheduler state encoding and command-word packing.
// DAC_BATCH_UPDATE_EN selects input-register writes followed by one update-all frame.
package dac_sched_pkg;

    localparam logic [3:0] CMD_WR_IN  = 4'h0;
    localparam logic [3:0] CMD_UPD_N  = 4'h1;
    localparam logic [3:0] CMD_WR_UPD = 4'h3;
    localparam logic [3:0] CMD_RESET  = 4'h7;
    localparam logic [3:0] CMD_REF    = 4'h8;
    localparam logic [3:0] ADDR_ALL   = 4'hF;

`ifdef DAC_BATCH_UPDATE_EN
    localparam logic [3:0] CMD_WR = CMD_WR_IN;
`else
    localparam logic [3:0] CMD_WR = CMD_WR_UPD;
`endif

    typedef enum logic [2:0] {
        S_INIT_RST,
        S_INIT_REF,
        S_IDLE,
        S_ISSUE,
`ifdef DAC_BATCH_UPDATE_EN
        S_WAIT,
        S_UPD
`else
        S_WAIT
`endif
    } state_e;

    // AD5628 frame: 4 don't-care, command, address, 12-bit data, 8 don't-care.
    function automatic logic [31:0] pack_cmd(input logic [3:0]  cmd,
                                             input logic [3:0]  addr,
                                             input logic [11:0] data);
        return {4'h0, cmd, addr, data, 8'h00};
    endfunction

endpackage

// File: rtl/dac_update_scheduler_if.sv
// Command handshake between the DAC scheduler (master) and the SPI shift engine (slave).
interface dac_update_scheduler_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_word;
    logic        cmd_done;

    modport master (
        output cmd_valid,
        output cmd_word,
        input  cmd_ready,
        input  cmd_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_word,
        output cmd_ready,
        output cmd_done
    );

endinterface

// File: rtl/rr_arbiter8.sv
// Combinational 8-way round-robin pick: first request at or after ptr_i, wrapping 7->0.
module rr_arbiter8 (
    input  logic [7:0] req_i,
    input  logic [2:0] ptr_i,
    output logic [7:0] gnt_o,
    output logic [2:0] idx_o
);

    logic       found;
    logic [2:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            pos = ptr_i + 3'(i);
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                idx_o      = pos;
                gnt_o[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_update_scheduler.sv
// Sequences AD5628 init frames, then coalesced round-robin channel writes to the SPI engine.
// Optional DAC_BATCH_UPDATE_EN: channel writes go to input regs, then one update-all frame.
module dac_update_scheduler
    import dac_sched_pkg::*;
#(
    parameter bit          INIT_REF = 1'b1,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic                          clk_sys,
    input  logic                          rst_sys,
    input  logic                          wr_en,
    input  logic [2:0]                    wr_ch,
    input  logic [11:0]                   wr_data,
    dac_update_scheduler_if.master        cmd,
    output logic [7:0]                    pending,
    output logic                          init_done,
    output logic                          busy,
    output logic                          err
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    state_e        ret_st_q, ret_st_d;   // where to go after cmd_done
    state_e        org_st_q, org_st_d;   // state that built the frame; retried on timeout
    logic [31:0]   cmd_word_q, cmd_word_d;
    logic [11:0]   shadow_q [8];
    logic [11:0]   shadow_d [8];
    logic [7:0]    pending_q, pending_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    gnt_ch_q, gnt_ch_d;
    logic          init_done_q, init_done_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
`ifdef DAC_BATCH_UPDATE_EN
    logic          sent_q, sent_d;
`endif

    logic [7:0] arb_gnt;
    logic [2:0] arb_idx;
    logic       tmo_hit;

    rr_arbiter8 u_arb (
        .req_i (pending_q),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        ret_st_d    = ret_st_q;
        org_st_d    = org_st_q;
        cmd_word_d  = cmd_word_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        ptr_d       = ptr_q;
        gnt_ch_d    = gnt_ch_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
`ifdef DAC_BATCH_UPDATE_EN
        sent_d      = sent_q;
`endif

        unique case (state_q)
            S_INIT_RST: begin
                cmd_word_d = pack_cmd(CMD_RESET, 4'h0, 12'h000);
                org_st_d   = S_INIT_RST;
                ret_st_d   = INIT_REF ? S_INIT_REF : S_IDLE;
                tmo_d      = '0;
                state_d    = S_ISSUE;
            end
            S_INIT_REF: begin
                cmd_word_d = pack_cmd(CMD_REF, 4'h0, 12'h001);
                org_st_d   = S_INIT_REF;
                ret_st_d   = S_IDLE;
                tmo_d      = '0;
                state_d    = S_ISSUE;
            end
            S_IDLE: begin
                if (init_done_q && (|pending_q)) begin
                    cmd_word_d = pack_cmd(CMD_WR, {1'b0, arb_idx}, shadow_q[arb_idx]);
                    pending_d  = pending_q & ~arb_gnt;
                    gnt_ch_d   = arb_idx;
                    ptr_d      = arb_idx + 3'd1;
                    org_st_d   = S_IDLE;
                    ret_st_d   = S_IDLE;
                    tmo_d      = '0;
                    state_d    = S_ISSUE;
`ifdef DAC_BATCH_UPDATE_EN
                    sent_d     = 1'b1;
                end else if (sent_q) begin
                    state_d    = S_UPD;
`endif
                end
            end
`ifdef DAC_BATCH_UPDATE_EN
            S_UPD: begin
                cmd_word_d = pack_cmd(CMD_UPD_N, ADDR_ALL, 12'h000);
                org_st_d   = S_UPD;
                ret_st_d   = S_IDLE;
                tmo_d      = '0;
                state_d    = S_ISSUE;
            end
`endif
            S_ISSUE: begin
                if (cmd.cmd_ready) begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = org_st_q;
                    if (org_st_q == S_IDLE) pending_d[gnt_ch_q] = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cmd.cmd_done) begin
                    state_d = ret_st_q;
`ifdef DAC_BATCH_UPDATE_EN
                    if (org_st_q == S_UPD) sent_d = 1'b0;
`endif
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = org_st_q;
                    if (org_st_q == S_IDLE) pending_d[gnt_ch_q] = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = S_INIT_RST;
        endcase

        // A new write wins over the grant clear, so the channel gets re-sent with fresh data.
        if (wr_en) begin
            shadow_d[wr_ch]  = wr_data;
            pending_d[wr_ch] = 1'b1;
        end

        init_done_d = init_done_q | (state_d == S_IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys) begin
            state_q     <= S_INIT_RST;
            ret_st_q    <= S_INIT_RST;
            org_st_q    <= S_INIT_RST;
            cmd_word_q  <= '0;
            shadow_q    <= '{default: '0};
            pending_q   <= '0;
            ptr_q       <= '0;
            gnt_ch_q    <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
`ifdef DAC_BATCH_UPDATE_EN
            sent_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ret_st_q    <= ret_st_d;
            org_st_q    <= org_st_d;
            cmd_word_q  <= cmd_word_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            gnt_ch_q    <= gnt_ch_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
`ifdef DAC_BATCH_UPDATE_EN
            sent_q      <= sent_d;
`endif
        end
    end

    assign cmd.cmd_valid = (state_q == S_ISSUE);
    assign cmd.cmd_word  = cmd_word_q;
    assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign pending       = pending_q;
    assign init_done     = init_done_q;
    assign err           = err_q;

endmodule
